pattern_scan_ctrl: RTL and testbench

Controller and scheduler for serial bit-pattern detection. A requester loads a programmable pattern, its length, a match target and an overlap mode through a valid/ready handshake. The block then arms a scan, samples a qualified serial bit stream, pulses on each match, counts matches and raises done when the target is reached. It generalises the fixed-pattern sequence detectors in the serial-input datapath to a run-time configured, start/abort sequenced unit.

---
 rtl/pattern_scan_ctrl_if.sv | 33 +++
 rtl/pattern_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_ctrl_if.sv
// Handshake, control and status bundle for pattern_scan_ctrl.
// master = requester/stream source, slave = scan controller.
interface pattern_scan_ctrl_if #(
  parameter int unsigned MaxLen = 8,
  parameter int unsigned CntW   = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [MaxLen-1:0] cfg_pattern;
  logic [3:0]        cfg_len;
  logic [CntW-1:0]   cfg_target;
  logic              cfg_overlap;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in_bit;
  logic              match;
  logic [CntW-1:0]   count;
  logic              busy;
  logic              done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_overlap,
    output start, abort, in_valid, in_bit,
    input  cfg_ready, match, count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_overlap,
    input  start, abort, in_valid, in_bit,
    output cfg_ready, match, count, busy, done
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Run-time configured serial pattern detector with start/abort sequencing,
// match counting and a target-count completion state.
module pattern_scan_ctrl #(
  parameter int unsigned MaxLen = 8,
  parameter int unsigned CntW   = 8
) (
  input logic               clk_i,
  input logic               reset_i,
  pattern_scan_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

  localparam logic [3:0] MaxLenW = 4'(MaxLen);

  state_e            state_q;
  logic              match_q, busy_q, done_q, ready_q;
  logic [CntW-1:0]   count_q;
  logic [MaxLen-2:0] hist_q;
  logic [3:0]        fill_q;
  logic [MaxLen-1:0] pat_q;
  logic [3:0]        len_q;
  logic [CntW-1:0]   tgt_q;
  logic              ovl_q;

  logic [MaxLen-1:0] new_hist;
  logic [MaxLen-1:0] mask;
  logic [3:0]        fill_inc;
  logic [3:0]        len_in;
  logic [CntW-1:0]   cnt_sat;
  logic [CntW:0]     cnt_next_w;
  logic              hit;
  logic              reach;

  always_comb begin
    new_hist = {hist_q, bus_io.in_bit};
    fill_inc = (fill_q >= MaxLenW) ? MaxLenW : fill_q + 4'd1;
    for (int i = 0; i < int'(MaxLen); i++) begin
      mask[i] = (4'(i) < len_q);
    end
    hit        = (fill_inc >= len_q) && (((new_hist ^ pat_q) & mask) == '0);
    cnt_sat    = (&count_q) ? count_q : count_q + CntW'(1);
    // Unsaturated compare so an all-ones target is still reachable.
    cnt_next_w = {1'b0, count_q} + (CntW + 1)'(1);
    reach      = (tgt_q != '0) && (cnt_next_w >= {1'b0, tgt_q});
    if (bus_io.cfg_len == 4'd0) begin
      len_in = 4'd1;
    end else if (bus_io.cfg_len > MaxLenW) begin
      len_in = MaxLenW;
    end else begin
      len_in = bus_io.cfg_len;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      count_q <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= 4'd1;
      tgt_q   <= '0;
      ovl_q   <= 1'b1;
    end else begin
      match_q <= 1'b0;
      if (bus_io.cfg_valid && ready_q) begin
        pat_q <= bus_io.cfg_pattern;
        len_q <= len_in;
        tgt_q <= bus_io.cfg_target;
        ovl_q <= bus_io.cfg_overlap;
      end
      case (state_q)
        StIdle, StDone: begin
          if (bus_io.abort) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (bus_io.start) begin
            state_q <= StArmed;
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        StArmed: begin
          if (bus_io.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (bus_io.in_valid) begin
            hist_q <= new_hist[MaxLen-2:0];
            fill_q <= (hit && !ovl_q) ? 4'd0 : fill_inc;
            if (hit) begin
              match_q <= 1'b1;
              count_q <= cnt_sat;
              if (reach) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                ready_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus_io.match     = match_q;
  assign bus_io.count     = count_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
  assign bus_io.cfg_ready = ready_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboarded bench for pattern_scan_ctrl: expected match bits are queued as each
// serial bit is driven and popped when the registered match output is sampled.
module tb_pattern_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.MaxLen(8), .CntW(8)) bus ();

  pattern_scan_ctrl #(.MaxLen(8), .CntW(8)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus_io (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v, input logic b, input logic ab, input logic e);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.abort    = ab;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.abort    = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt,
                        input logic ovl);
    @(negedge clk);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_target  = tgt;
    bus.cfg_overlap = ovl;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.match !== 1'b0 || bus.count !== 8'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs: match=%b count=%0d busy=%b done=%b ready=%b, want 0 0 0 0 1",
               bus.match, bus.count, bus.busy, bus.done, bus.cfg_ready);
    end
  endtask

  task automatic test_overlap();
    logic b[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic x[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic e;
    do_cfg(8'h02, 4'd3, 8'd0, 1'b1);
    do_start();
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b1, b[i], 1'b0, x[i]);
      e = exp_q.pop_front();
      total++;
      if (bus.match !== e) begin
        bad++;
        $display("FAIL overlap_match[%0d]: got %b want %b", i, bus.match, e);
      end
    end
    total++;
    if (bus.count !== 8'd2 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL overlap_count: count=%0d busy=%b want 2 1", bus.count, bus.busy);
    end
    do_abort();
  endtask

  task automatic test_non_overlap();
    logic b[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic x[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic e;
    do_cfg(8'h02, 4'd3, 8'd0, 1'b0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b1, b[i], 1'b0, x[i]);
      e = exp_q.pop_front();
      total++;
      if (bus.match !== e) begin
        bad++;
        $display("FAIL nonovl_match[%0d]: got %b want %b", i, bus.match, e);
      end
    end
    total++;
    if (bus.count !== 8'd1) begin
      bad++;
      $display("FAIL nonovl_count: got %0d want 1", bus.count);
    end
    do_abort();
  endtask

  task automatic test_target();
    logic x[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic e;
    do_cfg(8'h03, 4'd2, 8'd2, 1'b1);
    do_start();
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, 1'b1, 1'b0, x[i]);
      e = exp_q.pop_front();
      total++;
      if (bus.match !== e) begin
        bad++;
        $display("FAIL target_match[%0d]: got %b want %b", i, bus.match, e);
      end
      if (i == 2) begin
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
          bad++;
          $display("FAIL target_done_edge: done=%b busy=%b ready=%b want 1 0 1",
                   bus.done, bus.busy, bus.cfg_ready);
        end
      end
    end
    total++;
    if (bus.count !== 8'd2 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL target_hold: count=%0d done=%b want 2 1", bus.count, bus.done);
    end
    do_start();
    total++;
    if (bus.count !== 8'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL target_restart: count=%0d busy=%b done=%b want 0 1 0",
               bus.count, bus.busy, bus.done);
    end
    do_abort();
  endtask

  task automatic test_gaps();
    logic v[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic b[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic x[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic e;
    do_cfg(8'h02, 4'd3, 8'd0, 1'b1);
    do_start();
    for (int i = 0; i < 9; i++) begin
      drive_bit(v[i], b[i], 1'b0, x[i]);
      e = exp_q.pop_front();
      total++;
      if (bus.match !== e) begin
        bad++;
        $display("FAIL gaps_match[%0d]: got %b want %b", i, bus.match, e);
      end
    end
    total++;
    if (bus.count !== 8'd2) begin
      bad++;
      $display("FAIL gaps_count: got %0d want 2", bus.count);
    end
    do_abort();
  endtask

  task automatic test_abort();
    logic e;
    do_cfg(8'h03, 4'd2, 8'd0, 1'b1);
    do_start();
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    // Second 1 would match, but abort in the same cycle discards it.
    drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (bus.match !== e || bus.busy !== 1'b0 || bus.count !== 8'd0) begin
      bad++;
      $display("FAIL abort_beats_hit: match=%b busy=%b count=%0d want 0 0 0",
               bus.match, bus.busy, bus.count);
    end
    do_cfg(8'h03, 4'd2, 8'd1, 1'b1);
    do_start();
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    drive_bit(1'b1, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (bus.match !== e || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL abort_setup_done: match=%b done=%b want 1 1", bus.match, bus.done);
    end
    @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 ||
        bus.count !== 8'd1) begin
      bad++;
      $display("FAIL abort_start_done: done=%b busy=%b ready=%b count=%0d want 0 0 1 1",
               bus.done, bus.busy, bus.cfg_ready, bus.count);
    end
  endtask

  task automatic test_config_edges();
    logic b4[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] p = 8'hA5;
    logic e;
    do_cfg(8'h01, 4'd0, 8'd0, 1'b1);
    do_start();
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, b4[i], 1'b0, b4[i]);
      e = exp_q.pop_front();
      total++;
      if (bus.match !== e) begin
        bad++;
        $display("FAIL len0_match[%0d]: got %b want %b", i, bus.match, e);
      end
    end
    total++;
    if (bus.count !== 8'd3) begin
      bad++;
      $display("FAIL len0_count: got %0d want 3", bus.count);
    end
    do_abort();
    do_cfg(p, 4'd12, 8'd0, 1'b1);
    do_start();
    for (int i = 7; i >= 0; i--) begin
      drive_bit(1'b1, p[i], 1'b0, (i == 0));
      e = exp_q.pop_front();
      total++;
      if (bus.match !== e) begin
        bad++;
        $display("FAIL len12_match[%0d]: got %b want %b", 7 - i, bus.match, e);
      end
    end
    @(negedge clk);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = 8'h01;
    bus.cfg_len     = 4'd1;
    #1;
    total++;
    if (bus.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL armed_ready: got %b want 0", bus.cfg_ready);
    end
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    // Under the rejected len=1/pattern=1 config this bit would match.
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (bus.match !== e || bus.count !== 8'd1) begin
      bad++;
      $display("FAIL armed_cfg_ignored: match=%b count=%0d want %b 1", bus.match, bus.count, e);
    end
    do_abort();
  endtask

  task automatic test_async_reset();
    logic e;
    do_cfg(8'h03, 4'd2, 8'd0, 1'b1);
    do_start();
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    drive_bit(1'b1, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (bus.match !== e) begin
      bad++;
      $display("FAIL rst_setup_match: got %b want %b", bus.match, e);
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (bus.match !== 1'b0 || bus.count !== 8'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: match=%b count=%0d busy=%b done=%b ready=%b want 0 0 0 0 1",
               bus.match, bus.count, bus.busy, bus.done, bus.cfg_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    // Reset config is pattern=0, len=1: a lone 0 matches, a 1 does not.
    do_start();
    drive_bit(1'b1, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (bus.match !== e) begin
      bad++;
      $display("FAIL rst_cfg_zero: got %b want %b", bus.match, e);
    end
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (bus.match !== e || bus.count !== 8'd1) begin
      bad++;
      $display("FAIL rst_cfg_one: match=%b count=%0d want %b 1", bus.match, bus.count, e);
    end
    do_abort();
  endtask

  initial begin
    reset           = 1'b1;
    bus.cfg_valid   = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_target  = '0;
    bus.cfg_overlap = 1'b0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_bit      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_overlap();
    test_non_overlap();
    test_target();
    test_gaps();
    test_abort();
    test_config_edges();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
